inst_assembler: RTL

- Decode-side stage directly downstream of the instruction fetch unit.
- Consumes the registered instruction byte stream (one byte per valid cycle) and assembles complete 1-, 2- or 3-byte instructions.
- Presents each assembled instruction as one wide, registered word with its start PC to the decode/control logic.
- Provides backpressure to the control unit so fetch can be held while an assembled instruction waits.

---
 rtl/inst_assembler_pkg.sv | 40 ++++
 rtl/inst_assembler_out_reg.sv | 72 +++++++
 rtl/inst_assembler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/inst_assembler_pkg.sv
// -----------------------------------------------------------------------------
// inst_assembler_pkg
// Shared definitions for the instruction assembler: default byte/address
// widths, the instruction length classes, the position of the opcode class
// field, the assembler state encodings and the opcode-to-length decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package inst_assembler_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 12;
  localparam int OPC_CLASS_HI = 7;
  localparam int OPC_CLASS_LO = 6;

  // LEN_0 only ever appears in the output register straight out of reset.
  typedef enum logic [1:0] {
    LEN_0 = 2'd0,
    LEN_1 = 2'd1,
    LEN_2 = 2'd2,
    LEN_3 = 2'd3
  } len_e;

  typedef enum logic [1:0] {
    S_OPC = 2'd0,
    S_OP1 = 2'd1,
    S_OP2 = 2'd2
  } state_e;

  // The top two opcode bits select the instruction length: 11 carries a
  // 12-bit jump target in two extra bytes, 10 carries a one-byte immediate,
  // everything else stands alone.
  function automatic len_e inst_len_f(input logic [7:0] opcode);
    case (opcode[OPC_CLASS_HI:OPC_CLASS_LO])
      2'b11:   return LEN_3;
      2'b10:   return LEN_2;
      default: return LEN_1;
    endcase
  endfunction

endpackage

// File: rtl/inst_assembler_out_reg.sv
// -----------------------------------------------------------------------------
// inst_out_reg
// Valid/ready holding register for one assembled instruction.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset, clears valid and all fields
//   load_i     - a completed instruction is presented this cycle
//   consume_i  - downstream accepts the held instruction this cycle
//   flush_i    - redirect; drops any held instruction
//   opcode_i, operand_i, len_i, pc_i - fields of the instruction to load
//   vld_o      - held instruction valid
//   opcode_o, operand_o, len_o, pc_o - held instruction fields
// -----------------------------------------------------------------------------
module inst_out_reg
  import inst_assembler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                consume_i,
  input  logic                flush_i,
  input  logic [DATA_W-1:0]   opcode_i,
  input  logic [2*DATA_W-1:0] operand_i,
  input  logic [1:0]          len_i,
  input  logic [ADDR_W-1:0]   pc_i,
  output logic                vld_o,
  output logic [DATA_W-1:0]   opcode_o,
  output logic [2*DATA_W-1:0] operand_o,
  output logic [1:0]          len_o,
  output logic [ADDR_W-1:0]   pc_o
);

  logic                vld_q;
  logic [DATA_W-1:0]   opcode_q;
  logic [2*DATA_W-1:0] operand_q;
  logic [1:0]          len_q;
  logic [ADDR_W-1:0]   pc_q;

  // Flush beats everything. A load wins over a consume so that a new
  // instruction can replace the one being taken with no empty cycle between
  // them. The fields are only written on a load, which keeps them stable
  // while the instruction waits for the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
      len_q     <= LEN_0;
      pc_q      <= '0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (load_i) begin
      vld_q     <= 1'b1;
      opcode_q  <= opcode_i;
      operand_q <= operand_i;
      len_q     <= len_i;
      pc_q      <= pc_i;
    end else if (consume_i) begin
      vld_q <= 1'b0;
    end
  end

  assign vld_o     = vld_q;
  assign opcode_o  = opcode_q;
  assign operand_o = operand_q;
  assign len_o     = len_q;
  assign pc_o      = pc_q;

endmodule

// File: rtl/inst_assembler.sv
// -----------------------------------------------------------------------------
// inst_assembler
// Collects the fetched instruction byte stream into complete 1-, 2- or 3-byte
// instructions and hands each one to decode as a single registered word.
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous active-high reset
//   byte_vld     - fetch stage presents a byte this cycle
//   byte_i       - instruction byte
//   byte_pc      - address of byte_i
//   flush        - branch/return redirect, discards partial and held work
//   inst_rdy     - decode takes the held instruction this cycle
//   inst_vld     - assembled instruction valid
//   inst_opcode  - first byte of the instruction
//   inst_operand - {byte3, byte2}, absent bytes read as zero
//   inst_len     - instruction length in bytes (1..3)
//   inst_pc      - address of the opcode byte
//   fetch_hold   - asks the control unit to stall fetch
//   proto_err    - sticky: fetch sent a byte while fetch_hold was high
// -----------------------------------------------------------------------------
module inst_assembler
  import inst_assembler_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                byte_vld,
  input  logic [DATA_W-1:0]   byte_i,
  input  logic [ADDR_W-1:0]   byte_pc,
  input  logic                flush,
  input  logic                inst_rdy,
  output logic                inst_vld,
  output logic [DATA_W-1:0]   inst_opcode,
  output logic [2*DATA_W-1:0] inst_operand,
  output logic [1:0]          inst_len,
  output logic [ADDR_W-1:0]   inst_pc,
  output logic                fetch_hold,
  output logic                proto_err
);

  state_e              state_q;
  logic [DATA_W-1:0]   opcode_q;
  logic [DATA_W-1:0]   byte2_q;
  len_e                len_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                protoErr_q;

  logic                acc;
  logic                cmplt;
  logic [DATA_W-1:0]   cmpOpcode;
  logic [2*DATA_W-1:0] cmpOperand;
  len_e                cmpLen;
  logic [ADDR_W-1:0]   cmpPc;

  // While a finished instruction is stuck waiting for decode, no new byte
  // may be taken, so a completion can never collide with a held result.
  assign fetch_hold = inst_vld && !inst_rdy;
  assign acc        = byte_vld && !fetch_hold && !flush;

  // Work out whether the byte being accepted finishes an instruction and, if
  // so, what the finished word looks like. Operand bytes that the length does
  // not cover are forced to zero here rather than relying on the capture
  // registers.
  always_comb begin
    cmplt      = 1'b0;
    cmpOpcode  = opcode_q;
    cmpOperand = '0;
    cmpLen     = len_q;
    cmpPc      = pc_q;
    case (state_q)
      S_OPC: begin
        if (acc && (inst_len_f(byte_i) == LEN_1)) begin
          cmplt     = 1'b1;
          cmpOpcode = byte_i;
          cmpLen    = LEN_1;
          cmpPc     = byte_pc;
        end
      end
      S_OP1: begin
        if (acc && (len_q == LEN_2)) begin
          cmplt      = 1'b1;
          cmpOperand = {{DATA_W{1'b0}}, byte_i};
        end
      end
      S_OP2: begin
        if (acc) begin
          cmplt      = 1'b1;
          cmpOperand = {byte_i, byte2_q};
        end
      end
      default: begin
        cmplt = 1'b0;
      end
    endcase
  end

  // Byte capture state machine. The opcode byte fixes the length and start
  // PC for the whole instruction; later bytes only fill the operand. A flush
  // simply returns to the opcode state, which makes any partial capture
  // irrelevant. proto_err records a byte that fetch pushed while being held
  // off; that byte is never accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_OPC;
      opcode_q   <= '0;
      byte2_q    <= '0;
      len_q      <= LEN_0;
      pc_q       <= '0;
      protoErr_q <= 1'b0;
    end else begin
      if (byte_vld && fetch_hold && !flush) begin
        protoErr_q <= 1'b1;
      end
      if (flush) begin
        state_q <= S_OPC;
      end else if (acc) begin
        case (state_q)
          S_OPC: begin
            opcode_q <= byte_i;
            pc_q     <= byte_pc;
            len_q    <= inst_len_f(byte_i);
            byte2_q  <= '0;
            if (inst_len_f(byte_i) != LEN_1) begin
              state_q <= S_OP1;
            end
          end
          S_OP1: begin
            byte2_q <= byte_i;
            state_q <= (len_q == LEN_3) ? S_OP2 : S_OPC;
          end
          S_OP2: begin
            state_q <= S_OPC;
          end
          default: begin
            state_q <= S_OPC;
          end
        endcase
      end
    end
  end

  assign proto_err = protoErr_q;

  inst_out_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cmplt),
    .consume_i (inst_rdy),
    .flush_i   (flush),
    .opcode_i  (cmpOpcode),
    .operand_i (cmpOperand),
    .len_i     (cmpLen),
    .pc_i      (cmpPc),
    .vld_o     (inst_vld),
    .opcode_o  (inst_opcode),
    .operand_o (inst_operand),
    .len_o     (inst_len),
    .pc_o      (inst_pc)
  );

endmodule
